// File: rtl/sd_sector_arbiter_if.sv
// rtl/sd_sector_arbiter_if.sv - requester, engine and status signals of the SD sector arbiter
// master: requesters/engine side, slave: arbiter side.
interface sd_sector_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              init_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              wr_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_done;
  logic              sd_wr_en;
  logic              sd_rd_en;
  logic [ADDR_W-1:0] sd_addr;
  logic              sd_wr_busy;
  logic              sd_rd_busy;
  logic              arb_busy;
  logic              arb_err;

  modport master (
    output init_done, wr_req, wr_addr, rd_req, rd_addr, sd_wr_busy, sd_rd_busy,
    input  wr_ack, wr_done, rd_ack, rd_done, sd_wr_en, sd_rd_en, sd_addr, arb_busy, arb_err
  );

  modport slave (
    input  init_done, wr_req, wr_addr, rd_req, rd_addr, sd_wr_busy, sd_rd_busy,
    output wr_ack, wr_done, rd_ack, rd_done, sd_wr_en, sd_rd_en, sd_addr, arb_busy, arb_err
  );
endinterface

// File: rtl/sd_sector_arbiter.sv
// rtl/sd_sector_arbiter.sv - round-robin sharing of the SD sector engine between write and read paths
// Optional per-transaction watchdog: define SD_SECTOR_ARB_WATCHDOG_EN.
module sd_sector_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input logic               sys_clk,
  input logic               sys_rst,
  sd_sector_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT_HI,
    S_WR_WAIT_LO,
    S_RD_ISSUE,
    S_RD_WAIT_HI,
    S_RD_WAIT_LO
  } state_t;

  state_t            state;
  logic              last_grant_rd;
  logic              grant_wr;
  logic              grant_rd;
  logic [ADDR_W-1:0] grant_addr;
  logic              wd_expire;

  // On a tie the path that was not served last wins.
  assign grant_wr   = bus.wr_req && (!bus.rd_req || last_grant_rd);
  assign grant_rd   = bus.rd_req && !grant_wr;
  assign grant_addr = grant_wr ? bus.wr_addr : bus.rd_addr;

`ifdef SD_SECTOR_ARB_WATCHDOG_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wd_cnt <= '0;
    end else if (state == S_WR_ISSUE || state == S_RD_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_WR_WAIT_HI || state == S_WR_WAIT_LO ||
                 state == S_RD_WAIT_HI || state == S_RD_WAIT_LO) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign wd_expire = (wd_cnt == CNT_MAX);
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_WAIT_INIT;
      last_grant_rd <= 1'b1;
      bus.wr_ack    <= 1'b0;
      bus.wr_done   <= 1'b0;
      bus.rd_ack    <= 1'b0;
      bus.rd_done   <= 1'b0;
      bus.sd_wr_en  <= 1'b0;
      bus.sd_rd_en  <= 1'b0;
      bus.sd_addr   <= '0;
      bus.arb_busy  <= 1'b0;
      bus.arb_err   <= 1'b0;
    end else begin
      bus.wr_ack   <= 1'b0;
      bus.wr_done  <= 1'b0;
      bus.rd_ack   <= 1'b0;
      bus.rd_done  <= 1'b0;
      bus.sd_wr_en <= 1'b0;
      bus.sd_rd_en <= 1'b0;
      bus.arb_err  <= 1'b0;

      // Losing the card overrides everything; only an interrupted transaction is an error.
      if (state != S_WAIT_INIT && !bus.init_done) begin
        state        <= S_WAIT_INIT;
        bus.arb_busy <= 1'b1;
        bus.arb_err  <= (state != S_IDLE);
      end else begin
        case (state)
          S_WAIT_INIT: begin
            if (bus.init_done) begin
              state        <= S_IDLE;
              bus.arb_busy <= 1'b0;
            end else begin
              bus.arb_busy <= 1'b1;
            end
          end
          S_IDLE: begin
            if (grant_wr || grant_rd) begin
              bus.sd_addr   <= grant_addr;
              bus.arb_busy  <= 1'b1;
              last_grant_rd <= grant_rd;
              bus.wr_ack    <= grant_wr;
              bus.sd_wr_en  <= grant_wr;
              bus.rd_ack    <= grant_rd;
              bus.sd_rd_en  <= grant_rd;
              state         <= grant_wr ? S_WR_ISSUE : S_RD_ISSUE;
            end
          end
          S_WR_ISSUE: state <= S_WR_WAIT_HI;
          S_WR_WAIT_HI: begin
            if (wd_expire) begin
              state        <= S_IDLE;
              bus.arb_busy <= 1'b0;
              bus.arb_err  <= 1'b1;
            end else if (bus.sd_wr_busy) begin
              state <= S_WR_WAIT_LO;
            end
          end
          S_WR_WAIT_LO: begin
            if (wd_expire) begin
              state        <= S_IDLE;
              bus.arb_busy <= 1'b0;
              bus.arb_err  <= 1'b1;
            end else if (!bus.sd_wr_busy) begin
              state        <= S_IDLE;
              bus.arb_busy <= 1'b0;
              bus.wr_done  <= 1'b1;
            end
          end
          S_RD_ISSUE: state <= S_RD_WAIT_HI;
          S_RD_WAIT_HI: begin
            if (wd_expire) begin
              state        <= S_IDLE;
              bus.arb_busy <= 1'b0;
              bus.arb_err  <= 1'b1;
            end else if (bus.sd_rd_busy) begin
              state <= S_RD_WAIT_LO;
            end
          end
          S_RD_WAIT_LO: begin
            if (wd_expire) begin
              state        <= S_IDLE;
              bus.arb_busy <= 1'b0;
              bus.arb_err  <= 1'b1;
            end else if (!bus.sd_rd_busy) begin
              state        <= S_IDLE;
              bus.arb_busy <= 1'b0;
              bus.rd_done  <= 1'b1;
            end
          end
          default: begin
            state        <= S_WAIT_INIT;
            bus.arb_busy <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb/tb_sd_sector_arbiter.sv - directed self-checking bench for sd_sector_arbiter
// Build with SD_SECTOR_ARB_WATCHDOG_EN to exercise the watchdog timeout.
module tb_sd_sector_arbiter;

`ifdef SD_SECTOR_ARB_WATCHDOG_EN
  localparam int WR_BUSY_LEN = 30;
`else
  localparam int WR_BUSY_LEN = 100;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sd_sector_arbiter_if #(.ADDR_W(32)) bus ();

  sd_sector_arbiter #(.ADDR_W(32), .TIMEOUT_CYC(50)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.init_done = 1'b0;
    bus.wr_req = 1'b1;
    bus.wr_addr = 32'h0000_0ABC;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    bus.sd_wr_busy = 1'b0;
    bus.sd_rd_busy = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.wr_ack, bus.wr_done, bus.rd_ack, bus.rd_done, bus.sd_wr_en, bus.sd_rd_en,
         bus.arb_busy, bus.arb_err} !== 8'h00)
      begin errors++; $display("FAIL reset_outputs: got %b expected 00000000",
        {bus.wr_ack, bus.wr_done, bus.rd_ack, bus.rd_done, bus.sd_wr_en, bus.sd_rd_en,
         bus.arb_busy, bus.arb_err}); end
    checks++;
    if (bus.sd_addr !== 32'h0)
      begin errors++; $display("FAIL reset_sd_addr: got %h expected 0", bus.sd_addr); end
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if (bus.wr_ack !== 1'b0 || bus.sd_wr_en !== 1'b0 || bus.arb_busy !== 1'b1)
        begin errors++; $display("FAIL wait_init_cycle%0d: got ack=%b en=%b busy=%b expected 0 0 1",
          c, bus.wr_ack, bus.sd_wr_en, bus.arb_busy); end
    end
    bus.init_done = 1'b1;
    tick();
    checks++;
    if (bus.arb_busy !== 1'b0 || bus.wr_ack !== 1'b0)
      begin errors++; $display("FAIL idle_after_init: got busy=%b ack=%b expected 0 0",
        bus.arb_busy, bus.wr_ack); end
    tick();
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.sd_wr_en !== 1'b1 || bus.sd_addr !== 32'h0000_0ABC)
      begin errors++; $display("FAIL first_grant: got ack=%b en=%b addr=%h expected 1 1 00000abc",
        bus.wr_ack, bus.sd_wr_en, bus.sd_addr); end
    bus.wr_req = 1'b0;
    tick();
    bus.sd_wr_busy = 1'b1;
    tick();
    bus.sd_wr_busy = 1'b0;
    tick();
    checks++;
    if (bus.wr_done !== 1'b1)
      begin errors++; $display("FAIL first_done: got %b expected 1", bus.wr_done); end
    tick();
  endtask

  task automatic test_write();
    int early_done;
    early_done = 0;
    bus.wr_req = 1'b1;
    bus.wr_addr = 32'h0000_1000;
    tick();
    checks++;
    if (bus.wr_ack !== 1'b1 || bus.sd_wr_en !== 1'b1 || bus.rd_ack !== 1'b0 ||
        bus.sd_rd_en !== 1'b0 || bus.sd_addr !== 32'h0000_1000 || bus.arb_busy !== 1'b1)
      begin errors++; $display("FAIL wr_issue: got ack=%b en=%b rd_ack=%b rd_en=%b addr=%h busy=%b expected 1 1 0 0 00001000 1",
        bus.wr_ack, bus.sd_wr_en, bus.rd_ack, bus.sd_rd_en, bus.sd_addr, bus.arb_busy); end
    bus.wr_req = 1'b0;
    tick();
    checks++;
    if (bus.wr_ack !== 1'b0 || bus.sd_wr_en !== 1'b0)
      begin errors++; $display("FAIL wr_strobe_width: got ack=%b en=%b expected 0 0",
        bus.wr_ack, bus.sd_wr_en); end
    // Read-engine busy toggling must not advance a write transaction.
    bus.sd_rd_busy = 1'b1;
    tick();
    tick();
    bus.sd_rd_busy = 1'b0;
    bus.sd_wr_busy = 1'b1;
    for (int i = 0; i < WR_BUSY_LEN; i++) begin
      tick();
      if (bus.wr_done !== 1'b0 || bus.arb_busy !== 1'b1) early_done++;
    end
    checks++;
    if (early_done !== 0)
      begin errors++; $display("FAIL wr_no_early_done: got %0d bad cycles expected 0", early_done); end
    bus.sd_wr_busy = 1'b0;
    tick();
    checks++;
    if (bus.wr_done !== 1'b1 || bus.rd_done !== 1'b0 || bus.arb_busy !== 1'b0)
      begin errors++; $display("FAIL wr_done: got done=%b rd_done=%b busy=%b expected 1 0 0",
        bus.wr_done, bus.rd_done, bus.arb_busy); end
    tick();
    checks++;
    if (bus.wr_done !== 1'b0)
      begin errors++; $display("FAIL wr_done_width: got %b expected 0", bus.wr_done); end
  endtask

  task automatic test_read();
    bus.rd_req = 1'b1;
    bus.rd_addr = 32'h0000_2345;
    tick();
    checks++;
    if (bus.rd_ack !== 1'b1 || bus.sd_rd_en !== 1'b1 || bus.wr_ack !== 1'b0 ||
        bus.sd_wr_en !== 1'b0 || bus.sd_addr !== 32'h0000_2345)
      begin errors++; $display("FAIL rd_issue: got ack=%b en=%b wr_ack=%b wr_en=%b addr=%h expected 1 1 0 0 00002345",
        bus.rd_ack, bus.sd_rd_en, bus.wr_ack, bus.sd_wr_en, bus.sd_addr); end
    bus.rd_req = 1'b0;
    tick();
    bus.sd_rd_busy = 1'b1;
    tick();
    tick();
    bus.sd_rd_busy = 1'b0;
    tick();
    checks++;
    if (bus.rd_done !== 1'b1 || bus.wr_done !== 1'b0)
      begin errors++; $display("FAIL rd_done: got rd=%b wr=%b expected 1 0", bus.rd_done, bus.wr_done); end
  endtask

  task automatic test_round_robin();
    bus.wr_req = 1'b1;
    bus.wr_addr = 32'h0000_0010;
    bus.rd_req = 1'b1;
    bus.rd_addr = 32'h0000_0020;
    for (int g = 0; g < 4; g++) begin
      logic exp_rd;
      int   n;
      exp_rd = g[0];
      n = 0;
      while (!(bus.sd_wr_en || bus.sd_rd_en) && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 1)
        begin errors++; $display("FAIL rr_latency%0d: got %0d cycles expected 1", g, n); end
      checks++;
      if (bus.sd_rd_en !== exp_rd || bus.sd_wr_en !== !exp_rd ||
          bus.rd_ack !== exp_rd || bus.wr_ack !== !exp_rd)
        begin errors++; $display("FAIL rr_order%0d: got wr_en=%b rd_en=%b wr_ack=%b rd_ack=%b expected rd=%b",
          g, bus.sd_wr_en, bus.sd_rd_en, bus.wr_ack, bus.rd_ack, exp_rd); end
      checks++;
      if (bus.sd_addr !== (exp_rd ? 32'h0000_0020 : 32'h0000_0010))
        begin errors++; $display("FAIL rr_addr%0d: got %h expected %h", g, bus.sd_addr,
          exp_rd ? 32'h0000_0020 : 32'h0000_0010); end
      tick();
      if (exp_rd) bus.sd_rd_busy = 1'b1;
      else        bus.sd_wr_busy = 1'b1;
      tick();
      tick();
      tick();
      bus.sd_rd_busy = 1'b0;
      bus.sd_wr_busy = 1'b0;
      tick();
      checks++;
      if (bus.rd_done !== exp_rd || bus.wr_done !== !exp_rd)
        begin errors++; $display("FAIL rr_done%0d: got wr=%b rd=%b expected rd=%b",
          g, bus.wr_done, bus.rd_done, exp_rd); end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_stuck_engine();
    int bad;
    bad = 0;
    bus.wr_req = 1'b1;
    bus.wr_addr = 32'h0000_0300;
    tick();
    checks++;
    if (bus.wr_ack !== 1'b1)
      begin errors++; $display("FAIL stuck_ack: got %b expected 1", bus.wr_ack); end
    bus.wr_req = 1'b0;
    tick();
`ifdef SD_SECTOR_ARB_WATCHDOG_EN
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i < 50 && (bus.arb_err !== 1'b0 || bus.arb_busy !== 1'b1)) bad++;
    end
    checks++;
    if (bad !== 0)
      begin errors++; $display("FAIL wd_early: got %0d bad cycles expected 0", bad); end
    checks++;
    if (bus.arb_err !== 1'b1 || bus.wr_done !== 1'b0 || bus.arb_busy !== 1'b0)
      begin errors++; $display("FAIL wd_timeout: got err=%b done=%b busy=%b expected 1 0 0",
        bus.arb_err, bus.wr_done, bus.arb_busy); end
    tick();
    checks++;
    if (bus.arb_err !== 1'b0)
      begin errors++; $display("FAIL wd_err_width: got %b expected 0", bus.arb_err); end
`else
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.arb_busy !== 1'b1 || bus.arb_err !== 1'b0 || bus.wr_done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0)
      begin errors++; $display("FAIL stuck_holds: got %0d bad cycles expected 0", bad); end
    bus.sd_wr_busy = 1'b1;
    tick();
    bus.sd_wr_busy = 1'b0;
    tick();
    checks++;
    if (bus.wr_done !== 1'b1)
      begin errors++; $display("FAIL stuck_recover: got %b expected 1", bus.wr_done); end
`endif
    tick();
  endtask

  task automatic test_sys_rst();
    bus.wr_req = 1'b1;
    bus.wr_addr = 32'h0000_0777;
    tick();
    bus.wr_req = 1'b0;
    tick();
    bus.sd_wr_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.wr_ack, bus.wr_done, bus.rd_ack, bus.rd_done, bus.sd_wr_en, bus.sd_rd_en,
         bus.arb_busy, bus.arb_err} !== 8'h00 || bus.sd_addr !== 32'h0)
      begin errors++; $display("FAIL rst_mid_txn: got %b addr=%h expected 00000000 addr=0",
        {bus.wr_ack, bus.wr_done, bus.rd_ack, bus.rd_done, bus.sd_wr_en, bus.sd_rd_en,
         bus.arb_busy, bus.arb_err}, bus.sd_addr); end
    rst = 1'b0;
    bus.sd_wr_busy = 1'b0;
    tick();
    checks++;
    if (bus.wr_done !== 1'b0 || bus.arb_err !== 1'b0 || bus.arb_busy !== 1'b0)
      begin errors++; $display("FAIL rst_recover: got done=%b err=%b busy=%b expected 0 0 0",
        bus.wr_done, bus.arb_err, bus.arb_busy); end
    // The write was the last grant before reset; reset must restore write priority on a tie.
    bus.wr_req = 1'b1;
    bus.wr_addr = 32'h0000_0051;
    bus.rd_req = 1'b1;
    bus.rd_addr = 32'h0000_0052;
    tick();
    checks++;
    if (bus.sd_wr_en !== 1'b1 || bus.sd_rd_en !== 1'b0 || bus.sd_addr !== 32'h0000_0051)
      begin errors++; $display("FAIL rst_tie: got wr_en=%b rd_en=%b addr=%h expected 1 0 00000051",
        bus.sd_wr_en, bus.sd_rd_en, bus.sd_addr); end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    tick();
    bus.sd_wr_busy = 1'b1;
    tick();
    bus.sd_wr_busy = 1'b0;
    tick();
    checks++;
    if (bus.wr_done !== 1'b1)
      begin errors++; $display("FAIL rst_tie_done: got %b expected 1", bus.wr_done); end
    tick();
  endtask

  task automatic test_init_loss();
    bus.rd_req = 1'b1;
    bus.rd_addr = 32'h0000_0099;
    tick();
    bus.rd_req = 1'b0;
    tick();
    bus.sd_rd_busy = 1'b1;
    tick();
    tick();
    bus.init_done = 1'b0;
    tick();
    checks++;
    if (bus.arb_err !== 1'b1 || bus.rd_done !== 1'b0 || bus.arb_busy !== 1'b1 ||
        bus.sd_addr !== 32'h0000_0099)
      begin errors++; $display("FAIL init_loss: got err=%b done=%b busy=%b addr=%h expected 1 0 1 00000099",
        bus.arb_err, bus.rd_done, bus.arb_busy, bus.sd_addr); end
    tick();
    checks++;
    if (bus.arb_err !== 1'b0 || bus.rd_done !== 1'b0 || bus.arb_busy !== 1'b1)
      begin errors++; $display("FAIL init_loss_hold: got err=%b done=%b busy=%b expected 0 0 1",
        bus.arb_err, bus.rd_done, bus.arb_busy); end
    bus.sd_rd_busy = 1'b0;
    bus.init_done = 1'b1;
    tick();
    checks++;
    if (bus.arb_busy !== 1'b0 || bus.rd_done !== 1'b0)
      begin errors++; $display("FAIL init_regain: got busy=%b done=%b expected 0 0",
        bus.arb_busy, bus.rd_done); end
    bus.init_done = 1'b0;
    tick();
    checks++;
    if (bus.arb_err !== 1'b0 || bus.arb_busy !== 1'b1)
      begin errors++; $display("FAIL init_loss_idle: got err=%b busy=%b expected 0 1",
        bus.arb_err, bus.arb_busy); end
    bus.init_done = 1'b1;
    tick();
    checks++;
    if (bus.arb_busy !== 1'b0)
      begin errors++; $display("FAIL init_regain_idle: got %b expected 0", bus.arb_busy); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_stuck_engine();
    test_sys_rst();
    test_init_loss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
